// File: rtl/sd_req_arbiter_if.sv
// Bus bundle between the two sector clients, the arbiter and the upstream
// SD I/O controller. The arbiter takes the slave view; the environment
// (clients plus controller) takes the master view.
interface sd_req_arbiter_if;
    // client side
    logic        c0_rd;
    logic        c0_wr;
    logic        c1_rd;
    logic        c1_wr;
    logic [31:0] c0_lba;
    logic [31:0] c1_lba;
    logic [7:0]  c0_buff_din;
    logic [7:0]  c1_buff_din;
    logic        c0_ack;
    logic        c1_ack;
    logic        c0_buff_wr;
    logic        c1_buff_wr;
    logic        c0_done;
    logic        c1_done;
    logic        c0_err;
    logic        c1_err;

    // upstream controller side
    logic        sd_rd;
    logic        sd_wr;
    logic [31:0] sd_lba;
    logic        sd_ack;
    logic        sd_buff_wr;
    logic [7:0]  sd_buff_din;

    modport slave (
        input  c0_rd, c0_wr, c1_rd, c1_wr,
        input  c0_lba, c1_lba, c0_buff_din, c1_buff_din,
        output c0_ack, c1_ack, c0_buff_wr, c1_buff_wr,
        output c0_done, c1_done, c0_err, c1_err,
        output sd_rd, sd_wr, sd_lba, sd_buff_din,
        input  sd_ack, sd_buff_wr
    );

    modport master (
        output c0_rd, c0_wr, c1_rd, c1_wr,
        output c0_lba, c1_lba, c0_buff_din, c1_buff_din,
        input  c0_ack, c1_ack, c0_buff_wr, c1_buff_wr,
        input  c0_done, c1_done, c0_err, c1_err,
        input  sd_rd, sd_wr, sd_lba, sd_buff_din,
        output sd_ack, sd_buff_wr
    );
endinterface

// File: rtl/sd_req_arbiter.sv
// Two-client sector request arbiter in front of a single SD I/O controller.
// Round-robin grant, request/ack handshake upstream, WAIT_ACK timeout, and a
// drain state that swallows a stale sd_ack before any new grant.
module sd_req_arbiter #(
    parameter logic [23:0] TIMEOUT = 24'd16777215
) (
    input logic              clk_sys,
    input logic              reset,
    sd_req_arbiter_if.slave  bus
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_WAIT_ACK = 3'd1;
    localparam logic [2:0] S_XFER     = 3'd2;
    localparam logic [2:0] S_DONE     = 3'd3;
    localparam logic [2:0] S_DRAIN    = 3'd4;

    logic [2:0]  state_q, state_d;
    logic        gnt_q,   gnt_d;    // client currently owning the controller
    logic        last_q,  last_d;   // client served most recently
    logic        rd_q,    rd_d;
    logic        wr_q,    wr_d;
    logic [31:0] lba_q,   lba_d;
    logic [23:0] cnt_q,   cnt_d;    // WAIT_ACK age
    logic [1:0]  done_q,  done_d;
    logic [1:0]  err_q,   err_d;

    // client requests gathered as vectors indexed by client number
    logic [1:0]       cl_rd;
    logic [1:0]       cl_wr;
    logic [1:0]       cl_req;
    logic [1:0][31:0] cl_lba;
    logic             pick;
    logic             busy;
    logic             timed_out;
    logic [1:0]       ack_v;
    logic [1:0]       bwr_v;

    assign cl_rd     = {bus.c1_rd, bus.c0_rd};
    assign cl_wr     = {bus.c1_wr, bus.c0_wr};
    assign cl_req    = cl_rd | cl_wr;
    assign cl_lba    = {bus.c1_lba, bus.c0_lba};
    assign busy      = (state_q == S_WAIT_ACK) || (state_q == S_XFER);
    assign timed_out = (cnt_q >= TIMEOUT);

    // Single requester wins outright; on a tie the client not served last wins.
    assign pick = (cl_req == 2'b11) ? ~last_q : cl_req[1];

    // Next-state and datapath decisions for the grant FSM
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        lba_d   = lba_q;
        cnt_d   = cnt_q;
        done_d  = '0;
        err_d   = '0;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (bus.sd_ack) begin
                    // controller still finishing something we no longer own
                    state_d = S_DRAIN;
                end else if (|cl_req) begin
                    gnt_d   = pick;
                    lba_d   = cl_lba[pick];
                    // read wins when a client raises both
                    rd_d    = cl_rd[pick];
                    wr_d    = ~cl_rd[pick] & cl_wr[pick];
                    state_d = S_WAIT_ACK;
                end
            end

            S_WAIT_ACK: begin
                if (bus.sd_ack) begin
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    state_d = S_XFER;
                end else if (timed_out) begin
                    rd_d          = 1'b0;
                    wr_d          = 1'b0;
                    done_d[gnt_q] = 1'b1;
                    err_d[gnt_q]  = 1'b1;
                    // count the aborted attempt as service so a dead client
                    // cannot monopolise the controller through repeated retries
                    last_d        = gnt_q;
                    cnt_d         = '0;
                    state_d       = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 24'd1;
                end
            end

            S_XFER: begin
                if (!bus.sd_ack) begin
                    done_d[gnt_q] = 1'b1;
                    state_d       = S_DONE;
                end
            end

            S_DONE: begin
                last_d  = gnt_q;
                state_d = S_IDLE;
            end

            S_DRAIN: begin
                if (!bus.sd_ack) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers; reset parks in DRAIN if the controller is mid-ack
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q <= bus.sd_ack ? S_DRAIN : S_IDLE;
            gnt_q   <= 1'b0;
            last_q  <= 1'b1;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            lba_q   <= '0;
            cnt_q   <= '0;
            done_q  <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            lba_q   <= lba_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Per-client gating of the shared ack and read-data strobe
    for (genvar n = 0; n < 2; n++) begin : g_cl
        assign ack_v[n] = bus.sd_ack & busy & (gnt_q == 1'(n));
        assign bwr_v[n] = bus.sd_buff_wr & (state_q == S_XFER) & (gnt_q == 1'(n));
    end

    assign bus.c0_ack      = ack_v[0];
    assign bus.c1_ack      = ack_v[1];
    assign bus.c0_buff_wr  = bwr_v[0];
    assign bus.c1_buff_wr  = bwr_v[1];
    assign bus.c0_done     = done_q[0];
    assign bus.c1_done     = done_q[1];
    assign bus.c0_err      = err_q[0];
    assign bus.c1_err      = err_q[1];
    assign bus.sd_rd       = rd_q;
    assign bus.sd_wr       = wr_q;
    assign bus.sd_lba      = lba_q;
    assign bus.sd_buff_din = gnt_q ? bus.c1_buff_din : bus.c0_buff_din;

endmodule

// File: tb/tb_sd_req_arbiter.sv
// Bench for sd_req_arbiter: scenario tasks drive clients and a hand-played
// controller; a done-time scoreboard checks client, op, lba and err of every
// completed transaction against what each scenario queued up.
module tb_sd_req_arbiter;

    logic clk_sys = 1'b0;
    logic reset   = 1'b1;
    always #5 clk_sys = ~clk_sys;

    sd_req_arbiter_if bus();

    sd_req_arbiter #(.TIMEOUT(24'd100)) dut (
        .clk_sys (clk_sys),
        .reset   (reset),
        .bus     (bus)
    );

    typedef struct packed {
        logic        client;
        logic        wr;
        logic [31:0] lba;
        logic        err;
    } txn_t;

    txn_t        expq[$];
    int          checks = 0;
    int          errors = 0;
    logic        prev_iss = 1'b0;
    logic        cap_wr   = 1'b0;
    logic [31:0] cap_lba  = '0;

    // Scoreboard: capture the op at issue, compare at done
    always @(negedge clk_sys) begin
        txn_t e;
        txn_t got;
        if (!reset) begin
            if ((bus.sd_rd | bus.sd_wr) && !prev_iss) begin
                cap_wr  = bus.sd_wr;
                cap_lba = bus.sd_lba;
            end
            if (bus.c0_done | bus.c1_done) begin
                checks++;
                if (expq.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected_done c0_done=%0d c1_done=%0d", bus.c0_done, bus.c1_done);
                end else begin
                    e          = expq.pop_front();
                    got.client = bus.c1_done;
                    got.wr     = cap_wr;
                    got.lba    = cap_lba;
                    got.err    = bus.c0_err | bus.c1_err;
                    if ((got !== e) || (bus.c0_done & bus.c1_done)) begin
                        errors++;
                        $display("FAIL sb_txn got client=%0d wr=%0d lba=%h err=%0d both=%0d, want client=%0d wr=%0d lba=%h err=%0d",
                                 got.client, got.wr, got.lba, got.err, bus.c0_done & bus.c1_done,
                                 e.client, e.wr, e.lba, e.err);
                    end
                end
            end
        end
        prev_iss = bus.sd_rd | bus.sd_wr;
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk_sys);
            #1;
        end
    endtask

    task automatic push(input logic c, input logic w, input logic [31:0] l, input logic er);
        txn_t t;
        t.client = c;
        t.wr     = w;
        t.lba    = l;
        t.err    = er;
        expq.push_back(t);
    endtask

    task automatic clear_inputs();
        bus.c0_rd = 0; bus.c0_wr = 0; bus.c1_rd = 0; bus.c1_wr = 0;
        bus.c0_lba = '0; bus.c1_lba = '0;
        bus.c0_buff_din = '0; bus.c1_buff_din = '0;
        bus.sd_ack = 0; bus.sd_buff_wr = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        cyc(2);
        reset = 1'b0;
    endtask

    // Plays the controller for one transaction; ok=0 if a bounded wait expired.
    task automatic serve(input int dly, input int len, output bit ok);
        int n;
        ok = 1'b1;
        n  = 0;
        while (!(bus.sd_rd | bus.sd_wr) && n < 300) begin cyc(1); n++; end
        if (n >= 300) begin ok = 1'b0; return; end
        cyc(dly);
        bus.sd_ack = 1'b1;
        cyc(len);
        bus.sd_ack = 1'b0;
        n = 0;
        while (!(bus.c0_done | bus.c1_done) && n < 300) begin cyc(1); n++; end
        if (n >= 300) ok = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1'b1;
        cyc(3);
        checks++;
        if ({bus.sd_rd, bus.sd_wr} !== 2'b00) begin errors++; $display("FAIL reset_rdwr got %b want 00", {bus.sd_rd, bus.sd_wr}); end
        checks++;
        if (bus.sd_lba !== 32'h0) begin errors++; $display("FAIL reset_lba got %h want 0", bus.sd_lba); end
        checks++;
        if ({bus.c0_done, bus.c1_done, bus.c0_err, bus.c1_err} !== 4'b0) begin
            errors++; $display("FAIL reset_done_err got %b want 0000", {bus.c0_done, bus.c1_done, bus.c0_err, bus.c1_err});
        end
        reset = 1'b0;
        cyc(2);
        checks++;
        if ({bus.sd_rd, bus.sd_wr, bus.c0_ack, bus.c1_ack} !== 4'b0) begin
            errors++; $display("FAIL reset_idle got %b want 0000", {bus.sd_rd, bus.sd_wr, bus.c0_ack, bus.c1_ack});
        end
    endtask

    task automatic test_single_read();
        int bad;
        do_reset();
        bus.c0_rd  = 1'b1;
        bus.c0_lba = 32'h0000_0123;
        push(1'b0, 1'b0, 32'h123, 1'b0);
        cyc(1);
        checks++;
        if ({bus.sd_rd, bus.sd_wr} !== 2'b10 || bus.sd_lba !== 32'h123) begin
            errors++; $display("FAIL single_grant got rdwr=%b lba=%h want 10 00000123", {bus.sd_rd, bus.sd_wr}, bus.sd_lba);
        end
        cyc(2);
        checks++;
        if (bus.sd_rd !== 1'b1) begin errors++; $display("FAIL single_rd_hold got %b want 1", bus.sd_rd); end
        bus.sd_ack = 1'b1;
        #1;
        checks++;
        if ({bus.c0_ack, bus.c1_ack} !== 2'b10) begin errors++; $display("FAIL single_ack_gate got %b want 10", {bus.c0_ack, bus.c1_ack}); end
        cyc(1);
        checks++;
        if (bus.sd_rd !== 1'b0) begin errors++; $display("FAIL single_rd_drop got %b want 0", bus.sd_rd); end
        bad = 0;
        for (int i = 0; i < 599; i++) begin
            cyc(1);
            if (bus.c1_ack | bus.c1_done | bus.c1_err | bus.c1_buff_wr | bus.c0_done) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL single_quiet got %0d noisy cycles want 0", bad); end
        bus.sd_ack = 1'b0;
        cyc(1);
        checks++;
        if ({bus.c0_done, bus.c0_err, bus.c1_done} !== 3'b100) begin
            errors++; $display("FAIL single_done got %b want 100", {bus.c0_done, bus.c0_err, bus.c1_done});
        end
        bus.c0_rd = 1'b0;
        cyc(1);
        checks++;
        if (bus.c0_done !== 1'b0) begin errors++; $display("FAIL single_done_width got %b want 0", bus.c0_done); end
        cyc(2);
        checks++;
        if ({bus.sd_rd, bus.sd_wr} !== 2'b00) begin errors++; $display("FAIL single_no_regrant got %b want 00", {bus.sd_rd, bus.sd_wr}); end
    endtask

    task automatic test_tie_after_reset();
        bit ok;
        do_reset();
        bus.c0_wr = 1'b1; bus.c0_lba = 32'h0000_1000;
        bus.c1_rd = 1'b1; bus.c1_lba = 32'h0000_2000;
        push(1'b0, 1'b1, 32'h1000, 1'b0);
        push(1'b1, 1'b0, 32'h2000, 1'b0);
        cyc(1);
        checks++;
        if ({bus.sd_rd, bus.sd_wr} !== 2'b01 || bus.sd_lba !== 32'h1000) begin
            errors++; $display("FAIL tie_first got rdwr=%b lba=%h want 01 00001000", {bus.sd_rd, bus.sd_wr}, bus.sd_lba);
        end
        serve(1, 2, ok);
        checks++;
        if (!ok || bus.c0_done !== 1'b1) begin errors++; $display("FAIL tie_c0_done got ok=%0d done=%b want 1 1", ok, bus.c0_done); end
        bus.c0_wr = 1'b0;
        cyc(1);
        checks++;
        if ({bus.sd_rd, bus.sd_wr} !== 2'b00) begin errors++; $display("FAIL tie_idle_gap got %b want 00", {bus.sd_rd, bus.sd_wr}); end
        cyc(1);
        checks++;
        if ({bus.sd_rd, bus.sd_wr} !== 2'b10 || bus.sd_lba !== 32'h2000) begin
            errors++; $display("FAIL tie_second got rdwr=%b lba=%h want 10 00002000", {bus.sd_rd, bus.sd_wr}, bus.sd_lba);
        end
        serve(1, 2, ok);
        checks++;
        if (!ok || bus.c1_done !== 1'b1) begin errors++; $display("FAIL tie_c1_done got ok=%0d done=%b want 1 1", ok, bus.c1_done); end
        bus.c1_rd = 1'b0;
        cyc(2);
    endtask

    task automatic test_alternate();
        bit ok;
        do_reset();
        // c0 raises rd and wr together: read must be issued
        bus.c0_rd = 1'b1; bus.c0_wr = 1'b1; bus.c0_lba = 32'h0000_00A0;
        bus.c1_wr = 1'b1; bus.c1_lba = 32'h0000_00B0;
        push(1'b0, 1'b0, 32'hA0, 1'b0);
        push(1'b1, 1'b1, 32'hB0, 1'b0);
        push(1'b0, 1'b0, 32'hA1, 1'b0);
        push(1'b1, 1'b1, 32'hB1, 1'b0);
        cyc(1);
        bus.c0_lba = 32'h0000_00A1;
        cyc(1);
        checks++;
        if (bus.sd_lba !== 32'hA0 || bus.sd_rd !== 1'b1) begin
            errors++; $display("FAIL alt_lba_stable got lba=%h rd=%b want 000000a0 1", bus.sd_lba, bus.sd_rd);
        end
        for (int k = 0; k < 4; k++) begin
            serve(1, 2, ok);
            checks++;
            if (!ok) begin errors++; $display("FAIL alt_serve_%0d got timeout want done", k); end
            if (k == 1) bus.c1_lba = 32'h0000_00B1;
        end
        bus.c0_rd = 1'b0; bus.c0_wr = 1'b0; bus.c1_wr = 1'b0;
        cyc(3);
        checks++;
        if ({bus.sd_rd, bus.sd_wr} !== 2'b00) begin errors++; $display("FAIL alt_quiet got %b want 00", {bus.sd_rd, bus.sd_wr}); end
    endtask

    task automatic test_timeout();
        do_reset();
        bus.c1_rd  = 1'b1;
        bus.c1_lba = 32'h0000_0055;
        push(1'b1, 1'b0, 32'h55, 1'b1);
        cyc(1);
        checks++;
        if (bus.sd_rd !== 1'b1) begin errors++; $display("FAIL to_grant got %b want 1", bus.sd_rd); end
        cyc(100);
        checks++;
        if ({bus.sd_rd, bus.c1_done} !== 2'b10) begin errors++; $display("FAIL to_early got rd,done=%b want 10", {bus.sd_rd, bus.c1_done}); end
        cyc(1);
        checks++;
        if ({bus.sd_rd, bus.c1_done, bus.c1_err, bus.c0_done} !== 4'b0110) begin
            errors++; $display("FAIL to_fire got rd,done,err,c0done=%b want 0110", {bus.sd_rd, bus.c1_done, bus.c1_err, bus.c0_done});
        end
        bus.c1_rd = 1'b0;
        cyc(1);
        checks++;
        if ({bus.c1_done, bus.c1_err} !== 2'b00) begin errors++; $display("FAIL to_pulse got %b want 00", {bus.c1_done, bus.c1_err}); end
    endtask

    task automatic test_drain();
        bit ok;
        do_reset();
        bus.sd_ack = 1'b1;
        cyc(1);
        bus.c0_rd  = 1'b1;
        bus.c0_lba = 32'h0000_0009;
        cyc(4);
        checks++;
        if ({bus.sd_rd, bus.sd_wr, bus.c0_ack} !== 3'b000) begin
            errors++; $display("FAIL drain_hold got %b want 000", {bus.sd_rd, bus.sd_wr, bus.c0_ack});
        end
        push(1'b0, 1'b0, 32'h9, 1'b0);
        bus.sd_ack = 1'b0;
        cyc(1);
        checks++;
        if (bus.sd_rd !== 1'b0) begin errors++; $display("FAIL drain_exit got %b want 0", bus.sd_rd); end
        cyc(1);
        checks++;
        if (bus.sd_rd !== 1'b1) begin errors++; $display("FAIL drain_grant got %b want 1", bus.sd_rd); end
        serve(0, 3, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL drain_serve got timeout want done"); end
        bus.c0_rd = 1'b0;
        cyc(2);
    endtask

    task automatic test_reset_mid_xfer();
        bit ok;
        int bad;
        do_reset();
        bus.c0_rd  = 1'b1;
        bus.c0_lba = 32'h0000_3333;
        cyc(1);
        bus.sd_ack = 1'b1;
        cyc(3);
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        checks++;
        if ({bus.sd_rd, bus.c0_done, bus.sd_lba} !== {2'b00, 32'h0}) begin
            errors++; $display("FAIL rst_xfer_vals got rd=%b done=%b lba=%h want 0 0 0", bus.sd_rd, bus.c0_done, bus.sd_lba);
        end
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            cyc(1);
            if (bus.sd_rd | bus.sd_wr | bus.c0_ack | bus.c0_done) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL rst_xfer_drain got %0d active cycles want 0", bad); end
        push(1'b0, 1'b0, 32'h3333, 1'b0);
        bus.sd_ack = 1'b0;
        cyc(1);
        checks++;
        if (bus.sd_rd !== 1'b0) begin errors++; $display("FAIL rst_xfer_idle got %b want 0", bus.sd_rd); end
        cyc(1);
        checks++;
        if (bus.sd_rd !== 1'b1 || bus.sd_lba !== 32'h3333) begin
            errors++; $display("FAIL rst_xfer_regrant got rd=%b lba=%h want 1 00003333", bus.sd_rd, bus.sd_lba);
        end
        serve(1, 2, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL rst_xfer_serve got timeout want done"); end
        bus.c0_rd = 1'b0;
        cyc(2);
    endtask

    task automatic test_buff_wr();
        int n;
        do_reset();
        bus.c1_wr  = 1'b1;
        bus.c1_lba = 32'h0000_0077;
        push(1'b1, 1'b1, 32'h77, 1'b0);
        cyc(1);
        bus.sd_buff_wr = 1'b1;
        #1;
        checks++;
        if ({bus.c0_buff_wr, bus.c1_buff_wr} !== 2'b00) begin
            errors++; $display("FAIL bwr_wait_gate got %b want 00", {bus.c0_buff_wr, bus.c1_buff_wr});
        end
        bus.sd_buff_wr = 1'b0;
        bus.sd_ack     = 1'b1;
        cyc(1);
        for (int i = 0; i < 8; i++) begin
            bus.sd_buff_wr  = i[0];
            bus.c1_buff_din = 8'($urandom);
            bus.c0_buff_din = ~bus.c1_buff_din;
            #1;
            checks++;
            if ({bus.c0_buff_wr, bus.c1_buff_wr} !== {1'b0, i[0]}) begin
                errors++; $display("FAIL bwr_gate_%0d got %b want 0%0d", i, {bus.c0_buff_wr, bus.c1_buff_wr}, i[0]);
            end
            checks++;
            if (bus.sd_buff_din !== bus.c1_buff_din) begin
                errors++; $display("FAIL bwr_din_%0d got %h want %h", i, bus.sd_buff_din, bus.c1_buff_din);
            end
            cyc(1);
        end
        bus.sd_buff_wr = 1'b0;
        bus.sd_ack     = 1'b0;
        n = 0;
        while (!bus.c1_done && n < 20) begin cyc(1); n++; end
        checks++;
        if (n >= 20) begin errors++; $display("FAIL bwr_done got no c1_done want pulse"); end
        bus.c1_wr = 1'b0;
        cyc(2);
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_tie_after_reset();
        test_alternate();
        test_timeout();
        test_drain();
        test_reset_mid_xfer();
        test_buff_wr();
        cyc(2);
        checks++;
        if (expq.size() != 0) begin errors++; $display("FAIL sb_leftover got %0d pending want 0", expq.size()); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sd_req_arbiter.md
SD_REQ_ARBITER -- requirements
Module: sd_req_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 24'd16777215: WAIT_ACK cycle limit before a request is aborted.
REQ-002 clk_sys  input  1  system clock; all logic on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 c0_rd, c1_rd  input  1 each  client n sector read request (level).
REQ-005 c0_wr, c1_wr  input  1 each  client n sector write request (level).
REQ-006 c0_lba, c1_lba  input  32 each  client n sector address.
REQ-007 c0_buff_din, c1_buff_din  input  8 each  client n write data for the current sd_buff_addr.
REQ-008 c0_ack, c1_ack  output  1 each  gated copy of sd_ack for the granted client.
REQ-009 c0_buff_wr, c1_buff_wr  output  1 each  gated sd_buff_wr strobe for the granted client.
REQ-010 c0_done, c1_done  output  1 each  one-cycle pulse at transaction end.
REQ-011 c0_err, c1_err  output  1 each  one-cycle pulse coincident with done on timeout.
REQ-012 sd_rd, sd_wr  output  1 each  upstream request to the I/O controller.
REQ-013 sd_lba  output  32  upstream sector address.
REQ-014 sd_ack  input  1  upstream transfer acknowledge.
REQ-015 sd_buff_wr  input  1  upstream read-data strobe.
REQ-016 sd_buff_din  output  8  write data muxed from the granted client.
REQ-017 Ports sd_buff_addr (9) and sd_buff_dout (8) are broadcast to both clients outside this block; no arbiter port.

Function
REQ-018 States: IDLE, WAIT_ACK, XFER, DONE, DRAIN.
REQ-019 IDLE: client n requests when cn_rd|cn_wr; with one requester, grant it; with two, grant the client not served last (round-robin; client 0 first after reset).
REQ-020 Grant takes 1 cycle: request seen in IDLE at cycle N -> at N+1 state WAIT_ACK, sd_lba latched from the client, sd_rd or sd_wr asserted.
REQ-021 When a client asserts rd and wr together, rd is issued; wr is ignored for that transaction.
REQ-022 sd_lba and the rd/wr selection stay stable from grant until DONE, regardless of client input changes.
REQ-023 WAIT_ACK: on the first cycle sd_ack=1, deassert sd_rd/sd_wr on the next edge and enter XFER.
REQ-024 WAIT_ACK: a 24-bit counter increments each cycle; at TIMEOUT, drop sd_rd/sd_wr, pulse cn_done and cn_err, enter IDLE.
REQ-025 XFER: when sd_ack=0, enter DONE.
REQ-026 DONE: pulse cn_done for exactly one cycle, record the granted client as last-served, enter IDLE.
REQ-027 A client deasserts its request during its done cycle; a request still high in the following IDLE starts a new transaction.
REQ-028 cn_ack = sd_ack AND (state in WAIT_ACK/XFER) AND granted==n; the non-granted client's ack is 0.
REQ-029 cn_buff_wr = sd_buff_wr AND state==XFER AND granted==n.
REQ-030 sd_buff_din = c0_buff_din when granted==0, otherwise c1_buff_din (combinational mux on the registered grant).
REQ-031 sd_ack=1 observed in IDLE (spurious or left over) -> DRAIN; no grant until sd_ack=0, then IDLE.

Reset
REQ-032 Reset values: sd_rd=0, sd_wr=0, sd_lba=0, all cn_done/cn_err=0, counter=0, last-served=1 (client 0 wins first tie).
REQ-033 Reset during WAIT_ACK/XFER: outputs take reset values on the next edge; if sd_ack=1, state DRAIN, otherwise IDLE.

Verification
REQ-034 c0_rd=1, c0_lba=0x00000123; sd_ack high 3 cycles later for 600 cycles -> sd_rd=1 from cycle 1 to ack+1, sd_lba=0x123, c0_done pulse 1 cycle after ack falls, c1_* silent.
REQ-035 c0_wr and c1_rd raised same cycle after reset -> client 0 served first (sd_wr); then client 1 (sd_rd) granted the cycle after c0_done+1.
REQ-036 Both clients hold requests continuously across 4 transactions -> grants alternate 0,1,0,1.
REQ-037 TIMEOUT=100, c1_rd=1, sd_ack never rises -> sd_rd drops and c1_done=c1_err=1 at cycle 101 after grant.
REQ-038 Reset pulsed mid-XFER with sd_ack=1, c0_rd held -> sd_rd=0, no grant until sd_ack=0, then c0 granted next cycle.
REQ-039 sd_buff_wr strobes during c1 XFER -> only c1_buff_wr pulses; sd_buff_din tracks c1_buff_din.
